// File: rtl/ctrlr_poller_if.sv
// ctrlr_poller_if: controller read path between the memory controller and
// the pad poller.
//   ctrlr_re    read strobe; clears the addressed pad's new flag
//   addr_ctrlr  pad select 0-3 (peripheral addresses 0xFFF0-0xFFF3)
//   dout        {7'b0, new, buttons[7:0]} of the selected pad
// master = memory controller side, slave = ctrlr_poller side.
interface ctrlr_poller_if;
  logic        ctrlr_re;
  logic [1:0]  addr_ctrlr;
  logic [15:0] dout;

  modport master (output ctrlr_re, output addr_ctrlr, input dout);
  modport slave  (input ctrlr_re, input addr_ctrlr, output dout);
endinterface

// File: rtl/ctrlr_poller.sv
// ctrlr_poller: polls four 8-bit serial game pads every POLL_CYCLES cycles
// and keeps the latest button state plus a "new" flag per pad.
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   rd          read bus (slave): ctrlr_re, addr_ctrlr in; dout out
//   pad_data    serial data from pads 0-3, active-low, asynchronous
//   pad_latch   parallel-load strobe to all pads (registered)
//   pad_pulse   shift clock to all pads (registered)
//   frame_done  one-cycle pulse in the cycle a frame is committed
module ctrlr_poller #(
  parameter int CLK_DIV     = 4,
  parameter int POLL_CYCLES = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  ctrlr_poller_if.slave    rd,
  input  logic [3:0]       pad_data,
  output logic             pad_latch,
  output logic             pad_pulse,
  output logic             frame_done
);

  localparam int CW = $clog2(2 * CLK_DIV);
  localparam int PW = $clog2(POLL_CYCLES);

  typedef enum logic [2:0] {
    IDLE, LATCH, LOW, PULSE, COMMIT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [PW-1:0] pcnt_q;
  logic [3:0]    meta_q, sync_q;
  logic          pad_latch_q, pad_pulse_q, frame_done_q;
  logic          capture, commit, frame_start;
  logic [7:0]    btn_w [4];
  logic [3:0]    new_w;

  // Synchronizers reset to the idle (released, pulled-up) line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 4'hF;
      sync_q <= 4'hF;
    end else begin
      meta_q <= pad_data;
      sync_q <= meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q <= '0;
    end else if (pcnt_q == PW'(POLL_CYCLES - 1)) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_q + 1'b1;
    end
  end

  // The frame begins on the same edge that wraps pcnt to 0.
  assign frame_start = (state_q == IDLE) && (pcnt_q == PW'(POLL_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      pad_latch_q  <= 1'b0;
      pad_pulse_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      // Strobes decode the next state into flops so the pins never glitch.
      pad_latch_q  <= (state_d == LATCH);
      pad_pulse_q  <= (state_d == PULSE);
      frame_done_q <= (state_d == COMMIT);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    capture = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (frame_start) state_d = LATCH;
      end
      LATCH: begin
        if (cnt_q == CW'(2 * CLK_DIV - 1)) begin
          state_d = LOW;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      LOW: begin
        // Sample at the end of the low phase, when the pad output has settled.
        if (cnt_q == CW'(CLK_DIV - 1)) begin
          capture = 1'b1;
          cnt_d   = '0;
          state_d = (bit_q == 3'd7) ? COMMIT : PULSE;
        end
      end
      PULSE: begin
        if (cnt_q == CW'(CLK_DIV - 1)) begin
          cnt_d   = '0;
          bit_d   = bit_q + 1'b1;
          state_d = LOW;
        end
      end
      COMMIT: begin
        commit  = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_pad
      logic [7:0] shreg_q;
      logic [7:0] buttons_q;
      logic       new_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          shreg_q   <= '0;
          buttons_q <= '0;
          new_q     <= 1'b0;
        end else begin
          if (capture) shreg_q[bit_q] <= ~sync_q[gi];
          if (commit) buttons_q <= shreg_q;
          // A commit outranks a read-clear landing on the same edge.
          if (commit) begin
            new_q <= 1'b1;
          end else if (rd.ctrlr_re && (rd.addr_ctrlr == 2'(gi))) begin
            new_q <= 1'b0;
          end
        end
      end

      assign btn_w[gi] = buttons_q;
      assign new_w[gi] = new_q;
    end
  endgenerate

  assign rd.dout    = {7'b0, new_w[rd.addr_ctrlr], btn_w[rd.addr_ctrlr]};
  assign pad_latch  = pad_latch_q;
  assign pad_pulse  = pad_pulse_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ctrlr_poller.sv
module tb_ctrlr_poller;
  localparam int D    = 4;
  localparam int POLL = 100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] pad_data;
  logic       pad_latch, pad_pulse, frame_done;

  ctrlr_poller_if rd ();

  ctrlr_poller #(.CLK_DIV(D), .POLL_CYCLES(POLL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd         (rd.slave),
    .pad_data   (pad_data),
    .pad_latch  (pad_latch),
    .pad_pulse  (pad_pulse),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- pad models: 8-bit PISO, pressed pattern -> active-low line
  logic [7:0] pat    [4];
  logic [7:0] pad_sr [4];
  logic [7:0] snap   [4];

  always @(posedge pad_latch or posedge pad_pulse) begin
    for (int p = 0; p < 4; p++) begin
      if (pad_latch) pad_sr[p] <= pat[p];
      else           pad_sr[p] <= {1'b0, pad_sr[p][7:1]};
    end
  end

  always_comb begin
    pad_data = 4'hF;
    for (int p = 0; p < 4; p++) pad_data[p] = ~pad_sr[p][0];
  end

  // What the frame will deliver is the pattern present when the pads latch.
  always @(posedge pad_latch) begin
    for (int p = 0; p < 4; p++) snap[p] <= pat[p];
  end

  // ---------------- behavioural model: timing from cycles since release
  int         cyc;
  logic [7:0] m_btn [4];
  logic [3:0] m_new;

  function automatic int offs(input int c);
    return (c >= POLL) ? (c % POLL) : -1;
  endfunction

  function automatic logic exp_latch(input int c);
    int o;
    o = offs(c);
    return (o >= 0) && (o < 2 * D);
  endfunction

  function automatic logic exp_pulse(input int c);
    int o, r;
    o = offs(c);
    r = o - 2 * D;
    return (o >= 0) && (r >= 0) && (r < 15 * D) && (((r / D) % 2) == 1);
  endfunction

  function automatic logic exp_fd(input int c);
    return offs(c) == 17 * D;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc   <= 0;
      m_new <= 4'h0;
      for (int p = 0; p < 4; p++) m_btn[p] <= 8'h00;
    end else begin
      if (rd.ctrlr_re) m_new[rd.addr_ctrlr] <= 1'b0;
      if (exp_fd(cyc)) begin
        m_new <= 4'hF;
        for (int p = 0; p < 4; p++) m_btn[p] <= snap[p];
      end
      cyc <= cyc + 1;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    check("cyc_latch", {31'b0, pad_latch}, {31'b0, exp_latch(cyc)});
    check("cyc_pulse", {31'b0, pad_pulse}, {31'b0, exp_pulse(cyc)});
    check("cyc_fdone", {31'b0, frame_done}, {31'b0, exp_fd(cyc)});
    check("cyc_dout", {16'b0, rd.dout},
          {16'b0, 7'b0, m_new[rd.addr_ctrlr], m_btn[rd.addr_ctrlr]});
  end

  // ---------------- directed + random stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fd(input string name);
    int n;
    n = 0;
    while (!frame_done && n < 300) begin
      tick();
      n++;
    end
    if (!frame_done) check(name, 32'hDEAD, 32'h1);
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [15:0] exp);
    rd.addr_ctrlr = a;
    #1;
    check(name, {16'b0, rd.dout}, {16'b0, exp});
  endtask

  initial begin
    int n, w, o, np, pw, pwmin, pwmax, fd_at, rises;
    logic prev;

    rst_n = 1'b0;
    rd.ctrlr_re = 1'b0;
    rd.addr_ctrlr = 2'd0;
    pat[0] = 8'hA5; pat[1] = 8'h80; pat[2] = 8'hFF; pat[3] = 8'h00;
    repeat (3) tick();
    check("rst_dout", {16'b0, rd.dout}, 32'h0);
    check("rst_strobes", {30'b0, pad_latch, pad_pulse}, 32'h0);
    rst_n = 1'b1;

    // First latch exactly POLL cycles after release.
    n = 0;
    while (!pad_latch && n < 300) begin
      tick();
      n++;
    end
    check("first_latch_delay", n, 100);
    w = 0;
    while (pad_latch && w < 50) begin
      w++;
      tick();
    end
    check("latch_width", w, 8);

    // Rest of frame 1: pulse count/width and commit position.
    o = w; np = 0; pw = 0; pwmin = 99; pwmax = 0; fd_at = -1; prev = 1'b0;
    while (o < 200 && fd_at < 0) begin
      if (pad_pulse) pw++;
      else if (prev) begin
        np++;
        if (pw < pwmin) pwmin = pw;
        if (pw > pwmax) pwmax = pw;
        pw = 0;
      end
      prev = pad_pulse;
      if (frame_done) fd_at = o;
      tick();
      o++;
    end
    check("pulse_count", np, 7);
    check("pulse_wmin", pwmin, 4);
    check("pulse_wmax", pwmax, 4);
    check("fdone_69th_cycle", fd_at, 68);
    rd_chk("pad0_A5", 2'd0, 16'h01A5);

    // Frame 2: independent pads.
    pat[0] = 8'h01; pat[1] = 8'h80; pat[2] = 8'hFF; pat[3] = 8'h00;
    wait_fd("wait_f2");
    tick();
    rd_chk("ind_pad0", 2'd0, 16'h0101);
    rd_chk("ind_pad1", 2'd1, 16'h0180);
    rd_chk("ind_pad2", 2'd2, 16'h01FF);
    rd_chk("ind_pad3", 2'd3, 16'h0100);

    // Read-clear of pad 2 only.
    rd.addr_ctrlr = 2'd2;
    rd.ctrlr_re = 1'b1;
    tick();
    rd.ctrlr_re = 1'b0;
    rd_chk("clr_pad2", 2'd2, 16'h00FF);
    rd_chk("clr_keep_pad1", 2'd1, 16'h0180);
    rd.addr_ctrlr = 2'd0;
    rd.ctrlr_re = 1'b1;
    tick();
    rd.ctrlr_re = 1'b0;
    pat[0] = 8'h3C;

    // Frame 3: read of pad 0 lands in the commit cycle.
    wait_fd("wait_f3");
    rd_chk("coll_old_data", 2'd0, 16'h0001);
    rd.ctrlr_re = 1'b1;
    tick();
    rd.ctrlr_re = 1'b0;
    rd_chk("coll_commit_wins", 2'd0, 16'h013C);
    rd_chk("renew_pad2", 2'd2, 16'h01FF);

    // Frame 4: reset during the pulse for bit 4 (fifth pulse).
    rises = 0; prev = pad_pulse; n = 0;
    while (rises < 5 && n < 300) begin
      tick();
      n++;
      if (pad_pulse && !prev) rises++;
      prev = pad_pulse;
    end
    check("reach_bit4_pulse", rises, 5);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_strobes", {30'b0, pad_latch, pad_pulse}, 32'h0);
    rd_chk("midrst_dout", 2'd0, 16'h0000);
    repeat (2) tick();
    rst_n = 1'b1;
    n = 0;
    while (!frame_done && n < 400) begin
      tick();
      n++;
    end
    check("midrst_next_fdone", n, 168);

    // Random traffic over several frames.
    for (int k = 0; k < 900; k++) begin
      tick();
      if (frame_done)
        for (int p = 0; p < 4; p++) pat[p] = 8'($urandom);
      rd.addr_ctrlr = 2'($urandom_range(0, 3));
      rd.ctrlr_re   = ($urandom_range(0, 3) == 0);
    end
    rd.ctrlr_re = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
